// File: rtl/rle_block_sequencer.sv
// ---------------------------------------------------------------------------
// rle_block_sequencer
//
// Run-length encodes one block of BLOCK_LEN quantized coefficients (zig-zag
// order) into (run, value) tokens. Zeros are counted; each nonzero coefficient
// is emitted together with the number of zeros that preceded it. A block whose
// final coefficient is zero ends with an end-of-block (EOB) token instead.
//
// Optional feature (macro RLE_SEQ_ZRL_EN):
//   defined   - runs of 16 or more zeros are split into ZRL tokens (run=15,
//               value=0) so out_run never exceeds 15.
//   undefined - no ZRL splitting; out_run can reach 63.
//
// Parameters
//   BLOCK_LEN  coefficients per block, 2..64
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   coefficient present
//   in_ready   coefficient accepted when in_valid && in_ready
//   in_data    8-bit two's-complement coefficient
//   out_valid  token present
//   out_ready  token consumed when out_valid && out_ready
//   out_run    zeros preceding out_value
//   out_value  nonzero coefficient, or 0 for ZRL/EOB
//   out_eob    marks the end-of-block token
//   blk_done   one-cycle pulse after the block's final token is consumed
// ---------------------------------------------------------------------------
module rle_block_sequencer #(
    parameter int BLOCK_LEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_run,
    output logic [7:0] out_value,
    output logic       out_eob,
    output logic       blk_done
);

    localparam int                IDX_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_LEN - 1);

`ifdef RLE_SEQ_ZRL_EN
    typedef enum logic [1:0] {
        ACCEPT    = 2'd0,
        EMIT_ZRL  = 2'd1,
        EMIT_PAIR = 2'd2,
        EMIT_EOB  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ACCEPT    = 2'd0,
        EMIT_PAIR = 2'd2,
        EMIT_EOB  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [5:0]       run_q, run_d;
    logic             out_valid_d;
    logic [5:0]       out_run_d;
    logic [7:0]       out_value_d;
    logic             out_eob_d;
    // Set when the token currently held is the last one of its block.
    logic             out_last_q, out_last_d;
    logic             blk_done_d;
`ifdef RLE_SEQ_ZRL_EN
    // Nonzero coefficient waiting behind its ZRL tokens.
    logic [7:0]       pend_value_q, pend_value_d;
    logic             pend_last_q, pend_last_d;
    logic [5:0]       run_left;
`endif

    logic accept;
    logic consume;
    logic is_last;
    logic nonzero;

    // The token register may be refilled in the same cycle it is drained.
    // Reset is folded in so the port reads 0 while reset is held.
    assign in_ready = reset && (state_q == ACCEPT) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign is_last  = (idx_q == LAST_IDX);
    assign nonzero  = |in_data;
`ifdef RLE_SEQ_ZRL_EN
    assign run_left = run_q - 6'd16;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        run_d       = run_q;
        out_valid_d = out_valid;
        out_run_d   = out_run;
        out_value_d = out_value;
        out_eob_d   = out_eob;
        out_last_d  = out_last_q;
        blk_done_d  = consume && out_last_q;
`ifdef RLE_SEQ_ZRL_EN
        pend_value_d = pend_value_q;
        pend_last_d  = pend_last_q;
`endif

        case (state_q)
            ACCEPT: begin
                if (consume) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    idx_d = is_last ? '0 : idx_q + IDX_W'(1);
                    if (!nonzero) begin
                        if (!is_last) begin
                            run_d = run_q + 6'd1;
                        end else begin
                            // Trailing zeros collapse into a single EOB.
                            state_d     = EMIT_EOB;
                            run_d       = '0;
                            out_valid_d = 1'b1;
                            out_run_d   = '0;
                            out_value_d = '0;
                            out_eob_d   = 1'b1;
                            out_last_d  = 1'b1;
                        end
                    end else begin
`ifdef RLE_SEQ_ZRL_EN
                        if (run_q >= 6'd16) begin
                            // Run too long for one token: ZRLs go out first.
                            state_d      = EMIT_ZRL;
                            pend_value_d = in_data;
                            pend_last_d  = is_last;
                            out_valid_d  = 1'b1;
                            out_run_d    = 6'd15;
                            out_value_d  = '0;
                            out_eob_d    = 1'b0;
                            out_last_d   = 1'b0;
                        end else begin
                            run_d       = '0;
                            out_valid_d = 1'b1;
                            out_run_d   = run_q;
                            out_value_d = in_data;
                            out_eob_d   = 1'b0;
                            out_last_d  = is_last;
                        end
`else
                        run_d       = '0;
                        out_valid_d = 1'b1;
                        out_run_d   = run_q;
                        out_value_d = in_data;
                        out_eob_d   = 1'b0;
                        out_last_d  = is_last;
`endif
                    end
                end
            end

`ifdef RLE_SEQ_ZRL_EN
            EMIT_ZRL: begin
                if (consume) begin
                    run_d = run_left;
                    if (run_left < 6'd16) begin
                        // Remainder fits: the held value goes out next.
                        state_d     = EMIT_PAIR;
                        out_run_d   = run_left;
                        out_value_d = pend_value_q;
                        out_eob_d   = 1'b0;
                        out_last_d  = pend_last_q;
                    end
                end
            end
`endif

            EMIT_PAIR: begin
                if (consume) begin
                    state_d     = ACCEPT;
                    run_d       = '0;
                    out_valid_d = 1'b0;
                end
            end

            EMIT_EOB: begin
                if (consume) begin
                    state_d     = ACCEPT;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ACCEPT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ACCEPT;
            idx_q      <= '0;
            run_q      <= '0;
            out_valid  <= 1'b0;
            out_run    <= '0;
            out_value  <= '0;
            out_eob    <= 1'b0;
            out_last_q <= 1'b0;
            blk_done   <= 1'b0;
`ifdef RLE_SEQ_ZRL_EN
            // NOTE: the held value is pure data, but it is reset too so the
            // whole datapath comes out of reset in a known state.
            pend_value_q <= '0;
            pend_last_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values computed from the previous cycle's state.
            state_q    <= state_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            out_valid  <= out_valid_d;
            out_run    <= out_run_d;
            out_value  <= out_value_d;
            out_eob    <= out_eob_d;
            out_last_q <= out_last_d;
            blk_done   <= blk_done_d;
`ifdef RLE_SEQ_ZRL_EN
            pend_value_q <= pend_value_d;
            pend_last_q  <= pend_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_rle_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rle_block_sequencer
//
// Drives coefficient streams into two instances (BLOCK_LEN=64 and 4) and
// compares every consumed token with a block-level run-length model.
// Honours RLE_SEQ_ZRL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rle_block_sequencer;

    typedef struct packed {
        logic [5:0] run;
        logic [7:0] value;
        logic       eob;
    } tok_t;

`ifdef RLE_SEQ_ZRL_EN
    localparam bit ZRL = 1'b1;
`else
    localparam bit ZRL = 1'b0;
`endif

    localparam int M_ALWAYS = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_RAND   = 2;
    localparam int M_NEVER  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       drv_valid, drv_ready;
    logic [7:0] drv_data;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_eob, a_blk_done;
    logic [5:0] a_out_run;
    logic [7:0] a_out_value;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_eob, b_blk_done;
    logic [5:0] b_out_run;
    logic [7:0] b_out_value;

    logic       obs_valid, obs_in_ready, obs_eob, obs_blk_done;
    logic [5:0] obs_run;
    logic [7:0] obs_value;
    tok_t       obs_tok;

    int         vectors;
    int         miscompares;
    int         cyc;
    int         done_cnt;
    bit         hold_pend;
    bit         accepted;
    tok_t       held_tok;
    logic [7:0] stream[$];
    tok_t       exp_q[$];
    tok_t       got_q[$];

    always #5 clk = ~clk;

    assign a_in_valid  = !sel && drv_valid;
    assign a_out_ready = sel || drv_ready;
    assign b_in_valid  = sel && drv_valid;
    assign b_out_ready = !sel || drv_ready;

    assign obs_valid    = sel ? b_out_valid : a_out_valid;
    assign obs_in_ready = sel ? b_in_ready  : a_in_ready;
    assign obs_run      = sel ? b_out_run   : a_out_run;
    assign obs_value    = sel ? b_out_value : a_out_value;
    assign obs_eob      = sel ? b_out_eob   : a_out_eob;
    assign obs_blk_done = sel ? b_blk_done  : a_blk_done;
    assign obs_tok      = {obs_run, obs_value, obs_eob};

    rle_block_sequencer #(.BLOCK_LEN(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(drv_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_run(a_out_run), .out_value(a_out_value), .out_eob(a_out_eob),
        .blk_done(a_blk_done)
    );

    rle_block_sequencer #(.BLOCK_LEN(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(drv_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_run(b_out_run), .out_value(b_out_value), .out_eob(b_out_eob),
        .blk_done(b_blk_done)
    );

    task automatic check(input string tag, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, idx, got, exp);
        end
    endtask

    function automatic tok_t mk(input int r, input logic [7:0] v, input logic e);
        tok_t t;
        t.run   = 6'(r);
        t.value = v;
        t.eob   = e;
        return t;
    endfunction

    // Reference: each block on its own, straight from the run-length rules.
    function automatic void model(input int bl);
        int run;
        for (int b = 0; b < stream.size() / bl; b++) begin
            run = 0;
            for (int i = 0; i < bl; i++) begin
                logic [7:0] c;
                c = stream[b * bl + i];
                if (c == 8'd0) begin
                    if (i == bl - 1) exp_q.push_back(mk(0, 8'd0, 1'b1));
                    else run++;
                end else begin
                    while (ZRL && run >= 16) begin
                        exp_q.push_back(mk(15, 8'd0, 1'b0));
                        run -= 16;
                    end
                    exp_q.push_back(mk(run, c, 1'b0));
                    run = 0;
                end
            end
        end
    endfunction

    function automatic logic ready_val(input int mode);
        case (mode)
            M_ALWAYS: return 1'b1;
            M_TOGGLE: return (cyc % 2) == 0;
            M_RAND:   return $urandom_range(0, 3) != 0;
            default:  return 1'b0;
        endcase
    endfunction

    // Inputs are set at posedge+1; observe at posedge+2, then advance a cycle.
    task automatic tick();
        #1;
        if (hold_pend) begin
            check("stall_valid", cyc, obs_valid, 1);
            check("stall_token", cyc, obs_tok, held_tok);
        end
        hold_pend = obs_valid && !drv_ready;
        held_tok  = obs_tok;
        if (obs_valid && obs_value == 8'd0 && !obs_eob)
            check("zrl_in_ready", cyc, obs_in_ready, 0);
        if (obs_valid && drv_ready) got_q.push_back(obs_tok);
        if (obs_blk_done) done_cnt++;
        accepted = drv_valid && obs_in_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input int n, input int mode);
        int i      = 0;
        int budget = 0;
        while (i < n && budget < 40 * n + 200) begin
            drv_valid = (mode == M_RAND) ? ($urandom_range(0, 3) != 0) : 1'b1;
            drv_data  = stream[i];
            drv_ready = ready_val(mode);
            tick();
            if (accepted) i++;
            budget++;
        end
        drv_valid = 1'b0;
        check("feed_timeout", n, i, n);
    endtask

    task automatic drain(input int mode, input int nblk);
        int c = 0;
        int m = (mode == M_NEVER) ? M_ALWAYS : mode;
        while ((got_q.size() < exp_q.size() || done_cnt < nblk) && c < 3000) begin
            drv_ready = ready_val(m);
            tick();
            c++;
        end
        check("drain_timeout", c, c < 3000, 1);
        drv_ready = 1'b1;
        repeat (3) tick();
        check("idle_after_drain", 0, obs_valid, 0);
        check("token_count", 0, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("token", i, got_q[i], exp_q[i]);
        check("blk_done_count", 0, done_cnt, nblk);
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic run_stream(input logic s, input int bl, input int mode);
        sel = s;
        model(bl);
        feed(stream.size(), mode);
        drain(mode, stream.size() / bl);
        stream.delete();
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) stream.push_back(8'd0);
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < 80) stream.push_back(8'd0);
            else stream.push_back(8'($urandom_range(1, 255)));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        done_cnt    = 0;
        hold_pend   = 1'b0;
        accepted    = 1'b0;
        held_tok    = '0;
        sel         = 1'b0;
        drv_valid   = 1'b0;
        drv_ready   = 1'b0;
        drv_data    = 8'd0;
        reset       = 1'b0;

        // Reset state.
        #2;
        check("rst_out_valid", 0, a_out_valid, 0);
        check("rst_in_ready", 0, a_in_ready, 0);
        check("rst_token", 0, {a_out_run, a_out_value, a_out_eob}, 0);
        check("rst_blk_done", 0, a_blk_done, 0);
        check("rst_out_valid4", 0, b_out_valid, 0);
        #21;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 5,0,0,3 then 60 zeros -> (0,5),(2,3),EOB.
        stream = {8'd5, 8'd0, 8'd0, 8'd3};
        push_zeros(60);
        run_stream(1'b0, 64, M_ALWAYS);

        // 7, 20 zeros, -2, 42 zeros: ZRL split depends on the build.
        stream.push_back(8'd7);
        push_zeros(20);
        stream.push_back(8'hFE);
        push_zeros(42);
        run_stream(1'b0, 64, M_ALWAYS);

        // 64 nonzero values with out_ready toggling.
        for (int i = 1; i <= 64; i++) stream.push_back(8'(i));
        run_stream(1'b0, 64, M_TOGGLE);

        // Longest run ending on the last index, then an all-zero block.
        push_zeros(63);
        stream.push_back(8'h80);
        push_zeros(64);
        run_stream(1'b0, 64, M_RAND);

        // Random sparse blocks, back to back, random handshakes.
        push_random(64 * 3);
        run_stream(1'b0, 64, M_RAND);

        // Reset mid-block with a token pending.
        push_zeros(9);
        stream.push_back(8'd7);
        sel = 1'b0;
        feed(10, M_NEVER);
        check("pend_valid", 0, a_out_valid, 1);
        check("pend_token", 0, {a_out_run, a_out_value, a_out_eob}, mk(9, 8'd7, 1'b0));
        stream.delete();
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 0, a_out_valid, 0);
        check("mid_rst_in_ready", 0, a_in_ready, 0);
        check("mid_rst_token", 0, {a_out_run, a_out_value, a_out_eob}, 0);
        check("mid_rst_blk_done", 0, a_blk_done, 0);
        got_q.delete();
        hold_pend = 1'b0;
        done_cnt  = 0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        push_random(63);
        stream.push_back(8'd0);
        run_stream(1'b0, 64, M_RAND);

        // BLOCK_LEN=4: 0,0,0,9 then 0,0,0,0 back to back -> (3,9), EOB.
        stream = {8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
        run_stream(1'b1, 4, M_ALWAYS);

        push_random(4 * 12);
        run_stream(1'b1, 4, M_RAND);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
